pipe_sort_network: RTL and testbench

Parametrised, fully pipelined odd-even transposition sorting network. Accepts one packed vector of NUM_ELEMS unsigned words per cycle and emits it sorted, ascending or descending per vector, exactly NUM_ELEMS accepted-cycles later. It generalises the fixed 4/5-element pipe sorters: element count, element width and sort direction are configurable, and a valid/ready handshake with back-pressure is added. It sits between a packed-vector producer and a consumer that may stall.

---
 rtl/pipe_sort_network.sv | 90 +++++++++
 tb/tb_pipe_sort_network.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sort_network.sv
// Fully pipelined odd-even transposition sorter with per-vector sort direction.
// All stages advance together whenever the output register is empty or being taken.
module pipe_sort_network #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_ELEMS  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_ELEMS*DATA_WIDTH-1:0]  in_data,
  input  logic                             in_desc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEMS*DATA_WIDTH-1:0]  out_data,
  output logic                             out_desc
);

  localparam int VW = NUM_ELEMS * DATA_WIDTH;

  logic [VW-1:0] r_data [NUM_ELEMS];
  logic          r_desc [NUM_ELEMS];
  logic          r_vld  [NUM_ELEMS];

  logic [VW-1:0] w_src_data [NUM_ELEMS];
  logic          w_src_desc [NUM_ELEMS];
  logic          w_src_vld  [NUM_ELEMS];
  logic [VW-1:0] w_cx       [NUM_ELEMS];
  logic          w_adv;

  assign w_adv    = ~r_vld[NUM_ELEMS-1] | out_ready;
  assign in_ready = w_adv & rst_n;

  // Stage k sees the input port (k=0) or the register of stage k-1.
  always_comb begin
    w_src_data[0] = in_data;
    w_src_desc[0] = in_desc;
    w_src_vld[0]  = in_valid & in_ready;
    for (int k = 1; k < NUM_ELEMS; k++) begin
      w_src_data[k] = r_data[k-1];
      w_src_desc[k] = r_desc[k-1];
      w_src_vld[k]  = r_vld[k-1];
    end
  end

  always_comb begin : cmp_exchange
    logic [VW-1:0]         v_vec;
    logic [DATA_WIDTH-1:0] v_lo;
    logic [DATA_WIDTH-1:0] v_hi;
    v_vec = '0;
    v_lo  = '0;
    v_hi  = '0;
    for (int k = 0; k < NUM_ELEMS; k++) begin
      v_vec = w_src_data[k];
      // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
      for (int j = 0; j + 1 < NUM_ELEMS; j++) begin
        if ((j % 2) == (k % 2)) begin
          v_lo = v_vec[j*DATA_WIDTH +: DATA_WIDTH];
          v_hi = v_vec[(j+1)*DATA_WIDTH +: DATA_WIDTH];
          if (w_src_desc[k] ? (v_lo < v_hi) : (v_lo > v_hi)) begin
            v_vec[j*DATA_WIDTH +: DATA_WIDTH]     = v_hi;
            v_vec[(j+1)*DATA_WIDTH +: DATA_WIDTH] = v_lo;
          end
        end
      end
      w_cx[k] = v_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ELEMS; k++) begin
        r_data[k] <= '0;
        r_desc[k] <= 1'b0;
        r_vld[k]  <= 1'b0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < NUM_ELEMS; k++) begin
        r_data[k] <= w_cx[k];
        r_desc[k] <= w_src_desc[k];
        r_vld[k]  <= w_src_vld[k];
      end
    end
  end

  assign out_data  = r_data[NUM_ELEMS-1];
  assign out_desc  = r_desc[NUM_ELEMS-1];
  assign out_valid = r_vld[NUM_ELEMS-1];

endmodule

// File: tb/tb_pipe_sort_network.sv
// Bench for pipe_sort_network: directed vectors plus random traffic scored
// against a queue of software-sorted vectors with advance-count latency tracking.
module tb_pipe_sort_network;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_desc = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_desc;
  logic [VW-1:0] out_data;

  pipe_sort_network #(.DATA_WIDTH(W), .NUM_ELEMS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_desc(in_desc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_desc(out_desc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int miscompares = 0;
  int adv_cnt = 0;

  // Expected vectors in acceptance order, with the advance count at acceptance.
  logic [VW-1:0] q_data [$];
  logic          q_desc [$];
  int            q_adv  [$];

  logic          acc;
  logic [VW-1:0] vecs [8];
  logic [VW-1:0] pend_d;
  logic          pend_s;
  int            sent;
  int            cyc_n;

  function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] v, input logic d);
    int unsigned   e [$];
    int unsigned   t;
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) begin
      t = 32'(v[i*W +: W]);
      e.push_back(t);
    end
    if (d) e.rsort();
    else   e.sort();
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(e[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check against the model, clock, update the model.
  task automatic cyc(input logic iv, input logic [VW-1:0] d, input logic ds,
                     input logic ordy, output logic accepted);
    logic exp_ov;
    logic take;
    in_valid  = iv;
    in_data   = d;
    in_desc   = ds;
    out_ready = ordy;
    #1;
    exp_ov = (q_data.size() > 0) && ((adv_cnt - q_adv[0]) >= N);
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("in_ready", 64'(in_ready), 64'(!exp_ov || ordy));
    if (exp_ov) begin
      chk("out_data", 64'(out_data), 64'(q_data[0]));
      chk("out_desc", 64'(out_desc), 64'(q_desc[0]));
    end
    accepted = iv && (!exp_ov || ordy);
    take     = exp_ov && ordy;
    @(posedge clk);
    if (take) begin
      void'(q_data.pop_front());
      void'(q_desc.pop_front());
      void'(q_adv.pop_front());
    end
    if (accepted) begin
      q_data.push_back(ref_sort(d, ds));
      q_desc.push_back(ds);
      q_adv.push_back(adv_cnt);
      n_vec++;
    end
    if (!exp_ov || ordy) adv_cnt++;
    @(negedge clk);
  endtask

  task automatic drain();
    logic a;
    int   guard;
    guard = 0;
    while (q_data.size() > 0 && guard < 60) begin
      cyc(1'b0, '0, 1'b0, 1'b1, a);
      guard++;
    end
    chk("drain_left", 64'(q_data.size()), 64'd0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1, a);
  endtask

  // Push one vector into an empty pipe and check the constant result after N edges.
  task automatic one_shot(input string tag, input logic [VW-1:0] d, input logic ds,
                          input logic [VW-1:0] exp);
    logic a;
    cyc(1'b1, d, ds, 1'b1, a);
    repeat (N-1) cyc(1'b0, '0, 1'b0, 1'b1, a);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(exp));
    chk({tag, "_desc"}, 64'(out_desc), 64'(ds));
    cyc(1'b0, '0, 1'b0, 1'b1, a);
    chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_desc", 64'(out_desc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed vectors with hand-computed results
    one_shot("asc_7351", 12'h35F, 1'b0, 12'hF59);
    one_shot("desc_7351", 12'h35F, 1'b1, 12'h2EF);
    one_shot("dup_0707", 12'hE38, 1'b0, 12'hFC0);
    one_shot("all5_asc", 12'hB6D, 1'b0, 12'hB6D);
    one_shot("sorted_desc", 12'hF59, 1'b1, 12'h2EF);
    one_shot("rev_asc", 12'h2EF, 1'b0, 12'hF59);

    // Back-to-back mixed directions, then sorted/reverse inputs both ways
    cyc(1'b1, 12'h35F, 1'b0, 1'b1, acc);
    cyc(1'b1, 12'h35F, 1'b1, 1'b1, acc);
    cyc(1'b1, 12'hE38, 1'b0, 1'b1, acc);
    cyc(1'b1, 12'hF59, 1'b0, 1'b1, acc);
    cyc(1'b1, 12'h2EF, 1'b1, 1'b1, acc);
    cyc(1'b1, 12'hE38, 1'b1, 1'b1, acc);
    drain();

    // Back-pressure: 8 vectors with out_ready low for 3 cycles mid-stream
    for (int i = 0; i < 8; i++) vecs[i] = VW'($urandom);
    sent  = 0;
    cyc_n = 0;
    while (sent < 8 && cyc_n < 60) begin
      cyc(1'b1, vecs[sent], sent[0], !(cyc_n >= 5 && cyc_n < 8), acc);
      if (acc) sent++;
      cyc_n++;
    end
    chk("bp_sent", 64'(sent), 64'd8);
    drain();

    // Reset with three vectors in flight
    cyc(1'b1, 12'h35F, 1'b0, 1'b1, acc);
    cyc(1'b1, 12'hE38, 1'b1, 1'b1, acc);
    cyc(1'b1, 12'h2EF, 1'b0, 1'b1, acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_desc", 64'(out_desc), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    q_data.delete();
    q_desc.delete();
    q_adv.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    one_shot("post_rst", 12'h35F, 1'b1, 12'h2EF);
    drain();

    // Random traffic with random bubbles and stalls
    pend_d = VW'($urandom);
    pend_s = 1'($urandom);
    sent   = 0;
    cyc_n  = 0;
    while (sent < 1000 && cyc_n < 20000) begin
      cyc(($urandom % 4) != 0, pend_d, pend_s, ($urandom % 4) != 0, acc);
      if (acc) begin
        sent++;
        pend_d = VW'($urandom);
        pend_s = 1'($urandom);
      end
      cyc_n++;
    end
    chk("rand_sent", 64'(sent), 64'd1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
